bd_word_arbiter: RTL and testbench
==================================

Name: bd_word_arbiter

Overview:
- Shares the single BD downstream encoder input among NREQ requesters (e.g. PC host stream, on-FPGA spike generator, tag injector).
- Round-robin arbitration, one registered output stage.
- PROG_* leaves (codes 26-29) arrive as 2 consecutive half-words from one requester; the grant is locked across the pair so halves of different requesters never interleave ahead of the 2-to-1 deserializers.

Parameters:
- NREQ, 4, number of requesters (2..8)
- NPAYLOAD, 24, payload width (largest leaf payload)
- NCODE, 6, leaf-code width
- LOCK_TIMEOUT, 1024, max cycles a lock waits for the second half-word
- NCNT, 16, width of per-requester word counters

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_v  in  NREQ  per-requester valid
- in_leaf_code  in  NREQ*NCODE  packed leaf codes; requester i is at [i*NCODE +: NCODE]
- in_payload  in  NREQ*NPAYLOAD  packed payloads; same packing
- in_a  out  NREQ  per-requester ack
- out_v  out  1  valid to encoder
- out_leaf_code  out  NCODE  registered leaf code
- out_payload  out  NPAYLOAD  registered payload
- out_a  in  1  ack from encoder
- lock_err  out  1  sticky: lock timed out or broken
- clr_stat  in  1  synchronous clear of lock_err and all counters
- word_cnt  out  NREQ*NCNT  per-requester transferred-word counters, saturating

Behaviour:
- Transfer rule: a transfer happens on any rising clk where v&a. Ack is combinational from registered state plus current valid.
- Reset (reset=0, async): out_v=0, out_leaf_code=0, out_payload=0, in_a=0, lock_err=0, word_cnt=0, rr_ptr=0, state=ARB, lock_cnt=0.
- Output register:
  - load_en = ~out_v | out_a.
  - On load, the granted word is captured and out_v=1.
  - Otherwise, out_v is cleared after the out_a transfer.
  - Latency in->out is 1 cycle; sustained throughput is 1 word/cycle.
- ARB state:
  - grant = first valid requester at or after rr_ptr, searching cyclically.
  - in_a[g] = in_v[g] & load_en; all other in_a = 0.
  - On transfer: rr_ptr = (g+1) mod NREQ.
  - If the transferred code is in 26..29: state=LOCKED, lock_req=g, lock_code=code, lock_cnt=0.
- LOCKED state:
  - Only lock_req may be granted; other requesters stall.
  - On a lock_req transfer with code==lock_code: deliver it, state=ARB.
  - On a lock_req transfer with a different code: deliver it, set lock_err, state=ARB. If that new code is itself PROG, a new lock starts on it.
  - lock_cnt increments each cycle without a lock_req transfer. At LOCK_TIMEOUT-1: set lock_err, state=ARB, rr_ptr=lock_req+1.
- Counters: word_cnt[i] increments on each requester-i transfer and saturates at 2^NCNT-1.
- clr_stat: zeroes counters and lock_err; it does not affect arbitration. A transfer in the same cycle is not counted.
- Simultaneous events:
  - out_a and a new load in the same cycle: the register is overwritten and out_v stays 1.
  - Timeout in the same cycle as a lock_req transfer: the transfer wins and lock_err is not set.
- No requester valid: no acks; out_v drains after the out_a transfer.
- Reset mid-lock: lock is abandoned, and any word held in the output register is discarded.
- Leaf codes >= 34 pass through untouched; the downstream encoder swallows them.

Decomposition:
- Shared package bd_pkg holds:
  - NCODE=6, NPAYLOAD=24, NHORN=34
  - PROG code constants: AMMM=26, PAT=27, TAT0=28, TAT1=29
  - function is_prog(code)
  - arbiter state enum {ARB, LOCKED}
- Sub-module rr_grant: combinational round-robin priority picker with inputs req[NREQ], ptr and output one-hot grant. It is reusable by other merges.

Test Plan:
- Single stream, no contention: req0 sends codes 30, 23, 1 back-to-back with out_a=1 → same three words on out, 1-cycle latency, full throughput, word_cnt[0]=3.
- Round-robin fairness: all 4 requesters continuously send code 30 → grant order 0,1,2,3,0..., and each word_cnt equals 4 after 16 out transfers.
- PROG lock: req1 sends code 27 half-words A, B while req2 holds code 30 valid → out order A, B, then req2's word.
- Lock timeout: req0 sends one code-28 half, then drops valid, with LOCK_TIMEOUT=8 → req3 blocked for 8 cycles, lock_err=1, then req3 granted. After clr_stat pulse, lock_err=0.
- Backpressure: out_a=0 for 5 cycles with requesters valid → out_v=1 with the word stable, in_a=0 throughout, and no words lost or duplicated after out_a returns.
- Async reset asserted mid-lock, then released → all outputs 0 immediately, state ARB, rr_ptr=0, first grant goes to req0.

Source files
------------

// File: rtl/bd_pkg.sv
// Shared BD definitions: field widths, PROG leaf codes and arbiter state encoding.
package bd_pkg;

  localparam int unsigned NCODE    = 6;
  localparam int unsigned NPAYLOAD = 24;
  localparam int unsigned NHORN    = 34;

  localparam logic [NCODE-1:0] AMMM = 6'd26;
  localparam logic [NCODE-1:0] PAT  = 6'd27;
  localparam logic [NCODE-1:0] TAT0 = 6'd28;
  localparam logic [NCODE-1:0] TAT1 = 6'd29;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ARB    = 1'b0;
  localparam arb_state_t LOCKED = 1'b1;

  // PROG leaves travel as two half-words and must not be interleaved.
  function automatic logic is_prog(input logic [NCODE-1:0] code);
    return (code >= AMMM) && (code <= TAT1);
  endfunction

endpackage

// File: rtl/bd_word_arbiter_rr_grant.sv
// Combinational round-robin picker: one-hot grant to the first request at or after ptr.
module rr_grant #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant
);

  localparam int unsigned PW = $clog2(NREQ);

  logic            found;
  logic [PW-1:0]   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PW'((32'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bd_word_arbiter.sv
// Round-robin merge of NREQ word streams into one registered BD encoder input,
// holding the grant across PROG half-word pairs.
module bd_word_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned NPAYLOAD     = bd_pkg::NPAYLOAD,
  parameter int unsigned NCODE        = bd_pkg::NCODE,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned NCNT         = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          in_v,
  input  logic [NREQ*NCODE-1:0]    in_leaf_code,
  input  logic [NREQ*NPAYLOAD-1:0] in_payload,
  output logic [NREQ-1:0]          in_a,
  output logic                     out_v,
  output logic [NCODE-1:0]         out_leaf_code,
  output logic [NPAYLOAD-1:0]      out_payload,
  input  logic                     out_a,
  output logic                     lock_err,
  input  logic                     clr_stat,
  output logic [NREQ*NCNT-1:0]     word_cnt
);
  import bd_pkg::*;

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned LW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [IW-1:0]   LAST_REQ  = IW'(NREQ - 1);
  localparam logic [LW-1:0]   LOCK_LAST = LW'(LOCK_TIMEOUT - 1);
  localparam logic [NCNT-1:0] CNT_MAX   = '1;

  logic                out_v_q, out_v_d;
  logic [NCODE-1:0]    out_code_q, out_code_d;
  logic [NPAYLOAD-1:0] out_payload_q, out_payload_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  arb_state_t          state_q, state_d;
  logic [IW-1:0]       lock_req_q, lock_req_d;
  logic [NCODE-1:0]    lock_code_q, lock_code_d;
  logic [LW-1:0]       lock_cnt_q, lock_cnt_d;
  logic                lock_err_q, lock_err_d;
  logic [NCNT-1:0]     cnt_q [NREQ];
  logic [NCNT-1:0]     cnt_d [NREQ];

  logic                load_en, xfer, err_set;
  logic [NREQ-1:0]     lock_mask, req, grant, ack;
  logic [IW-1:0]       g_idx, next_ptr, lock_next_ptr;
  logic [NCODE-1:0]    sel_code;
  logic [NPAYLOAD-1:0] sel_payload;

  assign load_en = ~out_v_q | out_a;

  always_comb begin
    lock_mask             = '0;
    lock_mask[lock_req_q] = 1'b1;
  end

  assign req = (state_q == LOCKED) ? (in_v & lock_mask) : in_v;

  rr_grant #(
    .NREQ (NREQ)
  ) u_rr_grant (
    .req   (req),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  // Grant already implies valid; reset masks acks while the state is held.
  assign ack  = grant & {NREQ{load_en & reset}};
  assign xfer = |ack;

  always_comb begin
    g_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) g_idx = IW'(i);
    end
  end

  assign sel_code      = in_leaf_code[g_idx*NCODE +: NCODE];
  assign sel_payload   = in_payload[g_idx*NPAYLOAD +: NPAYLOAD];
  assign next_ptr      = (g_idx == LAST_REQ) ? '0 : g_idx + 1'b1;
  assign lock_next_ptr = (lock_req_q == LAST_REQ) ? '0 : lock_req_q + 1'b1;

  always_comb begin
    out_v_d       = out_v_q;
    out_code_d    = out_code_q;
    out_payload_d = out_payload_q;
    if (load_en) begin
      out_v_d = xfer;
      if (xfer) begin
        out_code_d    = sel_code;
        out_payload_d = sel_payload;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_req_d  = lock_req_q;
    lock_code_d = lock_code_q;
    lock_cnt_d  = lock_cnt_q;
    err_set     = 1'b0;
    if (xfer) rr_ptr_d = next_ptr;
    case (state_q)
      ARB: begin
        if (xfer && is_prog(sel_code)) begin
          state_d     = LOCKED;
          lock_req_d  = g_idx;
          lock_code_d = sel_code;
          lock_cnt_d  = '0;
        end
      end
      LOCKED: begin
        // A transfer in the timeout cycle still completes the pair cleanly.
        if (xfer) begin
          if (sel_code != lock_code_q) begin
            err_set = 1'b1;
            if (is_prog(sel_code)) begin
              lock_code_d = sel_code;
              lock_cnt_d  = '0;
            end else begin
              state_d = ARB;
            end
          end else begin
            state_d = ARB;
          end
        end else if (lock_cnt_q == LOCK_LAST) begin
          err_set  = 1'b1;
          state_d  = ARB;
          rr_ptr_d = lock_next_ptr;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  assign lock_err_d = clr_stat ? 1'b0 : (lock_err_q | err_set);

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_stat) begin
        cnt_d[i] = '0;
      end else if (ack[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_v_q       <= 1'b0;
      out_code_q    <= '0;
      out_payload_q <= '0;
      rr_ptr_q      <= '0;
      state_q       <= ARB;
      lock_req_q    <= '0;
      lock_code_q   <= '0;
      lock_cnt_q    <= '0;
      lock_err_q    <= 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      out_v_q       <= out_v_d;
      out_code_q    <= out_code_d;
      out_payload_q <= out_payload_d;
      rr_ptr_q      <= rr_ptr_d;
      state_q       <= state_d;
      lock_req_q    <= lock_req_d;
      lock_code_q   <= lock_code_d;
      lock_cnt_q    <= lock_cnt_d;
      lock_err_q    <= lock_err_d;
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign in_a          = ack;
  assign out_v         = out_v_q;
  assign out_leaf_code = out_code_q;
  assign out_payload   = out_payload_q;
  assign lock_err      = lock_err_q;

  for (genvar i = 0; i < NREQ; i++) begin : g_cnt_out
    assign word_cnt[i*NCNT +: NCNT] = cnt_q[i];
  end

endmodule

// File: tb/tb_bd_word_arbiter.sv
// Directed bench for bd_word_arbiter: streaming, fairness, PROG lock, timeout,
// backpressure and asynchronous reset mid-lock.
module tb_bd_word_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned NC   = 6;
  localparam int unsigned NP   = 24;
  localparam int unsigned NCNT = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      in_v;
  logic [NREQ*NC-1:0]   in_leaf_code;
  logic [NREQ*NP-1:0]   in_payload;
  logic [NREQ-1:0]      in_a;
  logic                 out_v;
  logic [NC-1:0]        out_leaf_code;
  logic [NP-1:0]        out_payload;
  logic                 out_a;
  logic                 lock_err;
  logic                 clr_stat;
  logic [NREQ*NCNT-1:0] word_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bd_word_arbiter #(
    .NREQ         (NREQ),
    .NPAYLOAD     (NP),
    .NCODE        (NC),
    .LOCK_TIMEOUT (8),
    .NCNT         (NCNT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_v          (in_v),
    .in_leaf_code  (in_leaf_code),
    .in_payload    (in_payload),
    .in_a          (in_a),
    .out_v         (out_v),
    .out_leaf_code (out_leaf_code),
    .out_payload   (out_payload),
    .out_a         (out_a),
    .lock_err      (lock_err),
    .clr_stat      (clr_stat),
    .word_cnt      (word_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [NC-1:0] c,
                         input logic [NP-1:0] p);
    in_v[i]               = v;
    in_leaf_code[i*NC +: NC] = c;
    in_payload[i*NP +: NP]   = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    in_v         = '0;
    in_leaf_code = '0;
    in_payload   = '0;
    out_a        = 1'b0;
    clr_stat     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_v", out_v, 0);
    chk("rst_code", out_leaf_code, 0);
    chk("rst_payload", out_payload, 0);
    chk("rst_in_a", in_a, 0);
    chk("rst_lock_err", lock_err, 0);
    chk("rst_word_cnt", word_cnt, 0);
    reset = 1'b1;

    // Single stream, full throughput, 1-cycle latency
    out_a = 1'b1;
    set_req(0, 1'b1, 6'd30, 24'h000A01);
    #1 chk("t1_ack_a", in_a, 4'b0001);
    tick();
    chk("t1_v_a", out_v, 1);
    chk("t1_code_a", out_leaf_code, 30);
    chk("t1_pay_a", out_payload, 24'h000A01);
    set_req(0, 1'b1, 6'd23, 24'h000A02);
    #1 chk("t1_ack_b", in_a, 4'b0001);
    tick();
    chk("t1_code_b", out_leaf_code, 23);
    chk("t1_pay_b", out_payload, 24'h000A02);
    set_req(0, 1'b1, 6'd1, 24'h000A03);
    tick();
    chk("t1_code_c", out_leaf_code, 1);
    chk("t1_pay_c", out_payload, 24'h000A03);
    set_req(0, 1'b0, 6'd0, 24'h0);
    #1 chk("t1_idle_ack", in_a, 0);
    tick();
    chk("t1_drain", out_v, 0);
    chk("t1_cnt", word_cnt, 64'd3);

    // Fresh start so the pointer begins at requester 0
    reset = 1'b0;
    #1 reset = 1'b1;

    // Round-robin fairness with all four requesters valid
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 6'd30, 24'(i));
    for (int n = 0; n < 16; n++) begin
      #1 chk("t2_grant", in_a, 64'(1) << (n % 4));
      tick();
      chk("t2_pay", out_payload, 64'(n % 4));
    end
    chk("t2_cnt", word_cnt, 64'h0004_0004_0004_0004);
    in_v = '0;
    tick();
    chk("t2_drain", out_v, 0);

    // PROG pair from req1 must not be split by req2
    set_req(1, 1'b1, 6'd27, 24'h0000B1);
    set_req(2, 1'b1, 6'd30, 24'h0000C2);
    #1 chk("t3_ack_a", in_a, 4'b0010);
    tick();
    chk("t3_pay_a", out_payload, 24'h0000B1);
    set_req(1, 1'b1, 6'd27, 24'h0000B2);
    #1 chk("t3_ack_b", in_a, 4'b0010);
    tick();
    chk("t3_pay_b", out_payload, 24'h0000B2);
    set_req(1, 1'b0, 6'd0, 24'h0);
    #1 chk("t3_ack_c", in_a, 4'b0100);
    tick();
    chk("t3_pay_c", out_payload, 24'h0000C2);
    chk("t3_no_err", lock_err, 0);
    set_req(2, 1'b0, 6'd0, 24'h0);
    tick();

    // Lock timeout: half-word from req0, then req3 waits LOCK_TIMEOUT cycles
    set_req(0, 1'b1, 6'd28, 24'h0000D0);
    #1 chk("t4_ack_lock", in_a, 4'b0001);
    tick();
    set_req(0, 1'b0, 6'd0, 24'h0);
    set_req(3, 1'b1, 6'd30, 24'h0000D3);
    for (int k = 0; k < 8; k++) begin
      #1 chk("t4_blocked", in_a, 0);
      chk("t4_err_low", lock_err, 0);
      tick();
    end
    chk("t4_err_set", lock_err, 1);
    #1 chk("t4_ack_r3", in_a, 4'b1000);
    tick();
    chk("t4_pay_r3", out_payload, 24'h0000D3);
    set_req(3, 1'b0, 6'd0, 24'h0);
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    chk("t4_clr_err", lock_err, 0);
    chk("t4_clr_cnt", word_cnt, 0);

    // Backpressure: word held stable, no acks, nothing lost or duplicated
    set_req(0, 1'b1, 6'd30, 24'h0000E0);
    set_req(1, 1'b1, 6'd30, 24'h0000E1);
    #1 chk("t5_ack0", in_a, 4'b0001);
    tick();
    chk("t5_pay0", out_payload, 24'h0000E0);
    set_req(0, 1'b0, 6'd0, 24'h0);
    out_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("t5_stall_ack", in_a, 0);
      tick();
      chk("t5_hold_v", out_v, 1);
      chk("t5_hold_pay", out_payload, 24'h0000E0);
    end
    out_a = 1'b1;
    #1 chk("t5_ack1", in_a, 4'b0010);
    tick();
    chk("t5_v1", out_v, 1);
    chk("t5_pay1", out_payload, 24'h0000E1);
    set_req(1, 1'b0, 6'd0, 24'h0);
    tick();
    chk("t5_drain", out_v, 0);
    chk("t5_cnt", word_cnt, 64'h0000_0000_0001_0001);

    // Asynchronous reset in the middle of a PROG lock with a word held
    set_req(2, 1'b1, 6'd26, 24'h0000F2);
    #1 chk("t6_ack_lock", in_a, 4'b0100);
    tick();
    chk("t6_held", out_payload, 24'h0000F2);
    out_a = 1'b0;
    set_req(2, 1'b1, 6'd30, 24'h0000F3);
    set_req(0, 1'b1, 6'd30, 24'h0000F0);
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_v", out_v, 0);
    chk("t6_rst_code", out_leaf_code, 0);
    chk("t6_rst_pay", out_payload, 0);
    chk("t6_rst_ack", in_a, 0);
    chk("t6_rst_cnt", word_cnt, 0);
    reset = 1'b1;
    #1 chk("t6_first_grant", in_a, 4'b0001);
    tick();
    chk("t6_first_v", out_v, 1);
    chk("t6_first_pay", out_payload, 24'h0000F0);
    in_v  = '0;
    out_a = 1'b1;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
